stoch_seq_ctrl: RTL and testbench
=================================

STOCH_SEQ_CTRL -- requirements
Module: stoch_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 9: operand and result width in bits; serial frame is WIDTH+1 bits.
REQ-002 Parameter WIN_LOG2, default 17: the evaluation window is 2^WIN_LOG2 cycles.
REQ-003 clk  input  1  only clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request one evaluation.
REQ-006 op_a_ser, op_b_ser  input  1 each  serial operands, LSB first.
REQ-007 res_data  input  WIDTH  result selected by res_sel, from the up-counter bank.
REQ-008 op_a, op_b  output  WIDTH  captured operands, to the SN generators.
REQ-009 lfsr_load, lfsr_en  output  1 each  LFSR reseed strobe and step enable.
REQ-010 cnt_clr, sn_en, cnt_latch  output  1 each  counter clear, count enable and average-capture strobe.
REQ-011 res_sel  output  2  result select: 0 = multiplier, 1 = adder, 2 = self-multiplier.
REQ-012 ser_out, frame  output  1 each  serial result bit and its qualifier.
REQ-013 busy, done  output  1 each  controller active; one-cycle completion pulse.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, CLEAR, RUN, LATCH, OUT, DONE; busy SHALL be 1 in every state except IDLE.
REQ-015 IDLE->LOAD SHALL occur on the edge that samples a start trigger (REQ-026); a trigger in any state other than IDLE SHALL be ignored.
REQ-016 LOAD SHALL last WIDTH+1 cycles, shifting op_a_ser/op_b_ser LSB first into op_a/op_b for the first WIDTH cycles; the last bit is a buffer bit and SHALL be discarded.
REQ-017 op_a/op_b SHALL hold their values from the end of LOAD until the next LOAD.
REQ-018 CLEAR SHALL last 1 cycle, with lfsr_load=1 and cnt_clr=1.
REQ-019 RUN SHALL last exactly 2^WIN_LOG2 cycles, with sn_en=1 and lfsr_en=1; a WIN_LOG2+1-bit window counter SHALL NOT wrap early.
REQ-020 LATCH SHALL last 1 cycle, with cnt_latch=1 and sn_en=0.
REQ-021 OUT SHALL last 3*(WIDTH+1) cycles, with res_sel stepping 0,1,2 for WIDTH+1 cycles each.
REQ-022 In OUT, each slot SHALL emit ser_out = res_data LSB first with frame=1 for WIDTH cycles, then one buffer cycle with ser_out=0 and frame=0.
REQ-023 res_data SHALL be sampled into a shift register on the first cycle of each slot.
REQ-024 DONE SHALL last 1 cycle with done=1, then go to IDLE (see REQ-029 for the alternative).
REQ-025 Latency: for start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH+3+2^WIN_LOG2+3*(WIDTH+1).
REQ-026 Without the macro, the start trigger SHALL be the rising edge of start (start=1 with the previous sample 0).
REQ-027 Strobes not named for a state SHALL be 0 in that state; res_sel SHALL be 0 outside OUT.

Reset
REQ-028 With rst_n=0 at an edge, the state SHALL become IDLE and all outputs 0, including op_a, op_b, the shift registers, the window counter and the start-edge register; reset mid-RUN or mid-OUT SHALL abort with no done pulse.

Configuration
REQ-029 Macro STOCH_SEQ_CONTINUOUS_EN: when defined, start SHALL be level-sensitive and DONE SHALL go directly to LOAD if start=1, with no IDLE cycle; when undefined, behaviour SHALL follow REQ-024/REQ-026, and a held-high start SHALL NOT retrigger.

Verification (WIDTH=9, WIN_LOG2=4)
REQ-030 Start pulse; op_a serial 0x155, op_b 0x0AB -> op_a=0x155, op_b=0x0AB after LOAD; done pulse exactly 58 edges after start sampled.
REQ-031 res_data held at 0x1A5 -> each of the 3 slots emits 1,0,1,0,0,1,0,1,1 with frame=1, then 0 with frame=0.
REQ-032 Count strobes -> cnt_clr and lfsr_load each high for 1 cycle; sn_en high for exactly 16 consecutive cycles; cnt_latch high 1 cycle immediately after.
REQ-033 Start pulse during RUN -> no effect; sequence timing unchanged.
REQ-034 rst_n=0 for 1 cycle at RUN cycle 8 -> all outputs 0 next cycle; IDLE; no done; a new start runs a full sequence.
REQ-035 start held at 1 -> without the macro, exactly one sequence runs; with STOCH_SEQ_CONTINUOUS_EN, back-to-back sequences run with LOAD immediately after DONE.

Source files
------------

// File: rtl/stoch_seq_ctrl_if.sv
// Bundle of the controller's start/operand/result handshake and strobe signals.
// Latency: none, wires only.
// Backpressure: none; the controller ignores start while a sequence is active.
interface stoch_seq_ctrl_if #(
    parameter int WIDTH = 9
);
    logic             start;
    logic             op_a_ser;
    logic             op_b_ser;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             lfsr_load;
    logic             lfsr_en;
    logic             cnt_clr;
    logic             sn_en;
    logic             cnt_latch;
    logic [1:0]       res_sel;
    logic             ser_out;
    logic             frame;
    logic             busy;
    logic             done;

    // Controller side
    modport slave (
        input  start, op_a_ser, op_b_ser, res_data,
        output op_a, op_b, lfsr_load, lfsr_en, cnt_clr, sn_en, cnt_latch,
               res_sel, ser_out, frame, busy, done
    );

    // Requester / datapath side
    modport master (
        output start, op_a_ser, op_b_ser, res_data,
        input  op_a, op_b, lfsr_load, lfsr_en, cnt_clr, sn_en, cnt_latch,
               res_sel, ser_out, frame, busy, done
    );
endinterface

// File: rtl/stoch_seq_ctrl.sv
// Sequencer for a stochastic-computing evaluation: serial operand load, counter window, serial result readout.
// Latency: done high WIDTH+3+2^WIN_LOG2+3*(WIDTH+1) cycles after the start trigger is sampled.
// Backpressure: none; triggers while busy are ignored. STOCH_SEQ_CONTINUOUS_EN makes start level-sensitive with back-to-back runs.
module stoch_seq_ctrl #(
    parameter int WIDTH    = 9,
    parameter int WIN_LOG2 = 17
) (
    input  logic               clk,
    input  logic               rst_n,
    stoch_seq_ctrl_if.slave    bus
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0]     LAST_BIT = BW'(WIDTH);
    localparam logic [WIN_LOG2:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

    typedef enum logic [2:0] {
        IDLE, LOAD, CLEAR, RUN, LATCH, OUT, DONE
    } state_t;

    state_t            state, state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [WIN_LOG2:0] win_cnt;
    logic [1:0]        slot;
    logic [WIDTH-1:0]  op_a_q, op_b_q;
    logic [WIDTH-1:0]  sh;
    logic              trig;

    logic              lfsr_load_c, lfsr_en_c, cnt_clr_c, sn_en_c, cnt_latch_c;
    logic [1:0]        res_sel_c;
    logic              ser_out_c, frame_c, busy_c, done_c;

`ifdef STOCH_SEQ_CONTINUOUS_EN
    assign trig = bus.start;
`else
    logic start_q;

    // Previous start sample for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= bus.start;
    end

    assign trig = bus.start & ~start_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Phase counters, operand capture and result shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            win_cnt <= '0;
            slot    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sh      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bit_cnt == LAST_BIT) begin
                        // trailing buffer bit is dropped
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        op_a_q  <= {bus.op_a_ser, op_a_q[WIDTH-1:1]};
                        op_b_q  <= {bus.op_b_ser, op_b_q[WIDTH-1:1]};
                    end
                end
                CLEAR: win_cnt <= '0;
                RUN:   win_cnt <= win_cnt + 1'b1;
                LATCH: begin
                    bit_cnt <= '0;
                    slot    <= '0;
                end
                OUT: begin
                    // capture on the first cycle of the slot, then shift out
                    if (bit_cnt == '0) sh <= bus.res_data >> 1;
                    else               sh <= sh >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        slot    <= slot + 2'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    bit_cnt <= '0;
                    win_cnt <= '0;
                    slot    <= '0;
                end
            endcase
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt   = state;
        lfsr_load_c = 1'b0;
        lfsr_en_c   = 1'b0;
        cnt_clr_c   = 1'b0;
        sn_en_c     = 1'b0;
        cnt_latch_c = 1'b0;
        res_sel_c   = 2'd0;
        ser_out_c   = 1'b0;
        frame_c     = 1'b0;
        busy_c      = 1'b1;
        done_c      = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (trig) state_nxt = LOAD;
            end
            LOAD: begin
                if (bit_cnt == LAST_BIT) state_nxt = CLEAR;
            end
            CLEAR: begin
                lfsr_load_c = 1'b1;
                cnt_clr_c   = 1'b1;
                state_nxt   = RUN;
            end
            RUN: begin
                sn_en_c   = 1'b1;
                lfsr_en_c = 1'b1;
                if (win_cnt == WIN_LAST) state_nxt = LATCH;
            end
            LATCH: begin
                cnt_latch_c = 1'b1;
                state_nxt   = OUT;
            end
            OUT: begin
                res_sel_c = slot;
                if (bit_cnt != LAST_BIT) begin
                    frame_c   = 1'b1;
                    // first bit comes straight from res_data before the capture lands
                    ser_out_c = (bit_cnt == '0) ? bus.res_data[0] : sh[0];
                end
                if (slot == 2'd2 && bit_cnt == LAST_BIT) state_nxt = DONE;
            end
            DONE: begin
                done_c = 1'b1;
`ifdef STOCH_SEQ_CONTINUOUS_EN
                state_nxt = bus.start ? LOAD : IDLE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.lfsr_load = lfsr_load_c;
    assign bus.lfsr_en   = lfsr_en_c;
    assign bus.cnt_clr   = cnt_clr_c;
    assign bus.sn_en     = sn_en_c;
    assign bus.cnt_latch = cnt_latch_c;
    assign bus.res_sel   = res_sel_c;
    assign bus.ser_out   = ser_out_c;
    assign bus.frame     = frame_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
endmodule

// File: tb/tb_stoch_seq_ctrl.sv
// Bench for stoch_seq_ctrl with WIDTH=9, WIN_LOG2=4.
// Reference model tracks cycles since the sampled trigger and derives outputs from the phase schedule.
module tb_stoch_seq_ctrl;
    localparam int W      = 9;
    localparam int WL     = 4;
    localparam int WIN    = 1 << WL;
    localparam int CLR_T  = W + 1;
    localparam int RUN_S  = W + 2;
    localparam int LAT_T  = RUN_S + WIN;
    localparam int OUT_S  = LAT_T + 1;
    localparam int DONE_T = OUT_S + 3 * (W + 1);

    logic clk;
    logic rst_n;

    stoch_seq_ctrl_if #(.WIDTH(W)) bus ();

    stoch_seq_ctrl #(.WIDTH(W), .WIN_LOG2(WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          t_seq  = -1;
    logic        sp     = 1'b0;
    logic [W-1:0] a_cur, b_cur, opa_e, opb_e;
    logic [W-1:0] bank [3];
    logic        garbage = 1'b0;
    int          done_exp = 0;
    int          done_obs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (seq cycle %0d)", tag, obs, exp, t_seq);
        end
    endtask

    // Expected {busy,done,lfsr_load,lfsr_en,cnt_clr,sn_en,cnt_latch,res_sel,frame,ser_out}
    function automatic logic [10:0] expv(input int t);
        logic [10:0] v;
        int slot, j;
        v = '0;
        if (t >= 0) begin
            v[10] = 1'b1;
            v[9]  = (t == DONE_T);
            v[8]  = (t == CLR_T);
            v[7]  = (t >= RUN_S && t < LAT_T);
            v[6]  = (t == CLR_T);
            v[5]  = (t >= RUN_S && t < LAT_T);
            v[4]  = (t == LAT_T);
            if (t >= OUT_S && t < DONE_T) begin
                slot    = (t - OUT_S) / (W + 1);
                j       = (t - OUT_S) % (W + 1);
                v[3:2]  = 2'(slot);
                if (j < W) begin
                    v[1] = 1'b1;
                    v[0] = bank[slot][j];
                end
            end
        end
        return v;
    endfunction

    function automatic int exp_sel(input int t);
        if (t >= OUT_S && t < DONE_T) return (t - OUT_S) / (W + 1);
        return 0;
    endfunction

    task automatic cycle(input logic s, input logic r);
        logic trig;
        int sel, j;
        bus.start = s;
        rst_n     = r;
        @(posedge clk);
        if (!r) begin
            t_seq = -1; sp = 1'b0; opa_e = '0; opb_e = '0;
        end else begin
`ifdef STOCH_SEQ_CONTINUOUS_EN
            trig = s;
`else
            trig = s & ~sp;
`endif
            if (t_seq < 0) begin
                if (trig) t_seq = 0;
            end else if (t_seq == DONE_T) begin
`ifdef STOCH_SEQ_CONTINUOUS_EN
                t_seq = s ? 0 : -1;
`else
                t_seq = -1;
`endif
            end else begin
                t_seq++;
            end
            sp = s;
            if (t_seq == W) begin
                opa_e = a_cur; opb_e = b_cur;
            end
            if (t_seq == DONE_T) done_exp++;
        end
        #1;
        if (t_seq >= 0 && t_seq < W) begin
            bus.op_a_ser = a_cur[t_seq];
            bus.op_b_ser = b_cur[t_seq];
        end else begin
            bus.op_a_ser = 1'($urandom);
            bus.op_b_ser = 1'($urandom);
        end
        sel = exp_sel(t_seq);
        j   = (t_seq >= OUT_S) ? (t_seq - OUT_S) % (W + 1) : 0;
        if (garbage && !(t_seq >= OUT_S && t_seq < DONE_T && j == 0))
            bus.res_data = W'($urandom);
        else
            bus.res_data = bank[sel];
        #1;
        check("ctrl", {21'd0, bus.busy, bus.done, bus.lfsr_load, bus.lfsr_en, bus.cnt_clr,
                       bus.sn_en, bus.cnt_latch, bus.res_sel, bus.frame, bus.ser_out},
              {21'd0, expv(t_seq)});
        if (t_seq < 0 || t_seq >= W)
            check("ops", {14'd0, bus.op_a, bus.op_b}, {14'd0, opa_e, opb_e});
        if (bus.done === 1'b1) done_obs++;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
    endtask

    task automatic randomize_ops;
        a_cur   = W'($urandom);
        b_cur   = W'($urandom);
        bank[0] = W'($urandom);
        bank[1] = W'($urandom);
        bank[2] = W'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_a_ser = 1'b0; bus.op_b_ser = 1'b0; bus.res_data = '0;
        a_cur = '0; b_cur = '0; opa_e = '0; opb_e = '0;
        bank[0] = '0; bank[1] = '0; bank[2] = '0;

        // Reset state
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        run_idle(2);

        // Directed operands and a held result word
        a_cur = 9'h155; b_cur = 9'h0AB;
        bank[0] = 9'h1A5; bank[1] = 9'h1A5; bank[2] = 9'h1A5;
        cycle(1'b1, 1'b1);
        run_idle(DONE_T + 4);
        check("ops_directed", {14'd0, bus.op_a, bus.op_b}, {14'd0, 9'h155, 9'h0AB});
        check("done_cnt_1", done_obs, done_exp);

        // Random operands, garbage on res_data outside slot start, start pulse in RUN
        garbage = 1'b1;
        randomize_ops();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 100 && t_seq != RUN_S + 5; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        run_idle(DONE_T);
        check("done_cnt_2", done_obs, done_exp);

        // Reset at RUN cycle 8 aborts, then a fresh sequence completes
        randomize_ops();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 100 && t_seq != RUN_S + 8; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("abort_idle", {31'd0, bus.busy}, 32'd0);
        run_idle(3);
        randomize_ops();
        cycle(1'b1, 1'b1);
        run_idle(DONE_T + 2);
        check("done_cnt_3", done_obs, done_exp);

        // Start held high
        randomize_ops();
        for (int i = 0; i < 2 * DONE_T + 10; i++) cycle(1'b1, 1'b1);
        run_idle(DONE_T + 3);
        check("done_cnt_4", done_obs, done_exp);

        // Random sequences with random gaps
        for (int k = 0; k < 3; k++) begin
            randomize_ops();
            run_idle($urandom_range(1, 5));
            cycle(1'b1, 1'b1);
            run_idle(DONE_T + 2);
        end
        check("done_cnt_5", done_obs, done_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
